regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised multi-port register file for the pipelined ARM datapath. One write port is one-hot decoded into per-register enables, generalising the fixed 32-output address decoder to any power-of-two depth with a gated enable. Adds a configurable number of read ports, a hardwired zero register, and write-to-read bypass. A pending-write scoreboard lets the hazard unit stall consumers of in-flight destinations.

## Interface
- DATA_WIDTH, 64, bits per register.
- NUM_REGS, 32, register count; power of two, ≥2 (elaboration-time assertion otherwise).
- NUM_READ, 2, number of read ports, ≥1.
- ZERO_REG, 1, if 1 register NUM_REGS-1 reads as 0, ignores writes and is never pending.
- BYPASS, 1, if 1 a same-cycle write is forwarded to matching read ports.
- AW = $clog2(NUM_REGS), derived localparam, not overridable.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- wr_en  in  1  commit wr_data to wr_addr at next rising edge.
- wr_addr  in  AW  destination register.
- wr_data  in  DATA_WIDTH  write data.
- issue_en  in  1  mark issue_addr pending at next rising edge.
- issue_addr  in  AW  destination of newly issued instruction.
- rd_addr  in  NUM_READ×AW  packed read addresses, port p at [p*AW +: AW].
- rd_data  out  NUM_READ×DATA_WIDTH  packed read data, port p at [p*DATA_WIDTH +: DATA_WIDTH].
- rd_pending  out  NUM_READ  1 = addressed register awaits a write.
- pending_vec  out  NUM_REGS  full scoreboard, bit i = register i pending.

## Operation
- Write decode: wr_addr decoded to NUM_REGS one-hot enables, all gated by wr_en; wr_en=0 → all enables 0. Exactly one register updates per write.
- Registers: storage array NUM_REGS×DATA_WIDTH, updated on rising clk when its enable is 1.
- Zero register (ZERO_REG=1): index NUM_REGS-1 never written, read returns 0, pending bit forced 0, issue to it ignored.
- Reads: combinational, independent per port; any number of ports may address the same register.
- Bypass (BYPASS=1): if wr_en and rd_addr[p]==wr_addr (and not zero reg), rd_data[p]=wr_data this cycle. BYPASS=0: old contents until after the edge.
- Scoreboard per register i (non-zero):
  - issue_en & issue_addr==i → pending[i] set next edge.
  - wr_en & wr_addr==i & not issued same cycle → pending[i] cleared next edge.
  - Issue and write same register same cycle → pending stays 1 (new producer wins).
  - Neither → hold.
- rd_pending[p] = pending[rd_addr[p]], except 0 when BYPASS=1 and the same-cycle write matches rd_addr[p] and no same-cycle issue targets it (value already forwarded).
- Write to a non-pending register is legal; data updates, pending stays 0.

## Timing
- reset asserted: all registers 0, all pending bits 0 immediately (asynchronous); rd_data reflects 0 combinationally, rd_pending=0, pending_vec=0.
- Reset release: first write/issue takes effect on the first rising edge with reset low.
- Reset asserted mid-operation overrides any write/issue on the same edge.
- Write latency: 1 edge to storage; 0 cycles to read via bypass.
- Issue latency: pending visible the cycle after issue_en.
- Read latency: combinational, 0 cycles; no registered outputs.
- Address wrap: none; AW exactly spans NUM_REGS.

## Test plan
- Reset: write 0xDEAD to r3, assert reset mid-cycle → rd_data for r3 = 0 immediately, pending_vec = 0.
- Write/read all ports: write r5=0x1234 edge N; cycle N+1 ports 0,1 both read r5 → 0x1234 on both; r4, r6 unchanged (one-hot check across all NUM_REGS addresses).
- Bypass: wr_en, wr_addr=7, wr_data=0xAA, rd_addr[0]=7 same cycle → rd_data[0]=0xAA (BYPASS=1), old value (BYPASS=0).
- Zero reg: write 0xFFFF to r31, issue r31 → reads 0, pending_vec[31]=0.
- Scoreboard: issue r2 → next cycle rd_pending=1 for port reading r2; write r2=0x55 → same cycle rd_pending=0 with data 0x55 (bypass), next cycle pending_vec[2]=0.
- Simultaneous issue+write r9 → pending_vec[9]=1 next cycle, data updated to written value; repeat with NUM_REGS=8, NUM_READ=3, DATA_WIDTH=32.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Multi-port register file with one-hot write decode, optional hardwired
// zero register, optional write-to-read bypass and a per-register
// pending-write scoreboard used by the hazard unit to stall consumers.
module regfile_scoreboard #(
  parameter  int DATA_WIDTH = 64,
  parameter  int NUM_REGS   = 32,
  parameter  int NUM_READ   = 2,
  parameter  int ZERO_REG   = 1,
  parameter  int BYPASS     = 1,
  localparam int AW         = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [AW-1:0]                  wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           issue_en,
  input  logic [AW-1:0]                  issue_addr,
  input  logic [NUM_READ*AW-1:0]         rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]            rd_pending,
  output logic [NUM_REGS-1:0]            pending_vec
);

  localparam bit HAS_ZERO   = (ZERO_REG != 0);
  localparam bit HAS_BYPASS = (BYPASS != 0);

  // Depth must be a power of two so AW spans the register space exactly.
  if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_depth
    $error("regfile_scoreboard: NUM_REGS must be a power of two >= 2");
  end
  if (NUM_READ < 1) begin : g_bad_ports
    $error("regfile_scoreboard: NUM_READ must be >= 1");
  end

  // Address-match vectors. wr_onehot is already gated by wr_en and is
  // never set for the zero register, so it doubles as the bypass-hit map.
  logic [NUM_REGS-1:0]                 wr_sel;
  logic [NUM_REGS-1:0]                 wr_onehot;
  logic [NUM_REGS-1:0]                 issue_sel;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_view;

  genvar gi;

  // Per-register decode, storage and scoreboard bit.
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [AW-1:0] IDX     = AW'(gi);
    localparam bit            IS_ZERO = HAS_ZERO && (gi == NUM_REGS - 1);

    assign wr_sel[gi]    = (wr_addr == IDX);
    assign issue_sel[gi] = (issue_addr == IDX);
    assign wr_onehot[gi] = wr_en && wr_sel[gi] && !IS_ZERO;

    if (IS_ZERO) begin : g_zero
      // Hardwired zero: no storage, never pending, issues ignored.
      assign reg_view[gi]    = '0;
      assign pending_vec[gi] = 1'b0;
    end else begin : g_live
      logic [DATA_WIDTH-1:0] data_reg;
      logic                  pending_reg;

      // Register storage: load write data when this register's enable fires.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_reg <= '0;
        end else if (wr_onehot[gi]) begin
          data_reg <= wr_data;
        end
      end

      // Scoreboard bit: issue sets (and beats a same-cycle write), write clears.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pending_reg <= 1'b0;
        end else if (issue_en && issue_sel[gi]) begin
          pending_reg <= 1'b1;
        end else if (wr_onehot[gi]) begin
          pending_reg <= 1'b0;
        end
      end

      assign reg_view[gi]    = data_reg;
      assign pending_vec[gi] = pending_reg;
    end
  end

  // Read ports: combinational lookup with optional same-cycle forwarding.
  for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [AW-1:0] raddr;
    logic          fwd;
    logic          reissue;

    assign raddr   = rd_addr[gi*AW +: AW];
    assign fwd     = HAS_BYPASS && wr_onehot[raddr];
    assign reissue = issue_en && issue_sel[raddr];

    assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = fwd ? wr_data : reg_view[raddr];
    // A forwarded value satisfies the consumer unless a newer producer is
    // being issued to the same register in this cycle.
    assign rd_pending[gi] = (fwd && !reissue) ? 1'b0 : pending_vec[raddr];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
// Self-checking bench: default configuration driven from a vector table,
// plus hand sequences for BYPASS=0, an 8x32 three-port build and reset.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // Default configuration: 64 bits, 32 regs, 2 ports, zero reg, bypass.
  logic         wr_en, issue_en;
  logic [4:0]   wr_addr, issue_addr;
  logic [63:0]  wr_data;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   rd_pending;
  logic [31:0]  pending_vec;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_pending(rd_pending), .pending_vec(pending_vec)
  );

  // No-bypass build.
  logic         nb_wr_en, nb_issue_en;
  logic [4:0]   nb_wr_addr, nb_issue_addr;
  logic [63:0]  nb_wr_data;
  logic [9:0]   nb_rd_addr;
  logic [127:0] nb_rd_data;
  logic [1:0]   nb_rd_pending;
  logic [31:0]  nb_pending_vec;

  regfile_scoreboard #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .wr_en(nb_wr_en), .wr_addr(nb_wr_addr), .wr_data(nb_wr_data),
    .issue_en(nb_issue_en), .issue_addr(nb_issue_addr), .rd_addr(nb_rd_addr),
    .rd_data(nb_rd_data), .rd_pending(nb_rd_pending), .pending_vec(nb_pending_vec)
  );

  // Small build: 8 regs, 3 ports, 32 bits.
  logic        e_wr_en, e_issue_en;
  logic [2:0]  e_wr_addr, e_issue_addr;
  logic [31:0] e_wr_data;
  logic [8:0]  e_rd_addr;
  logic [95:0] e_rd_data;
  logic [2:0]  e_rd_pending;
  logic [7:0]  e_pending_vec;

  regfile_scoreboard #(.DATA_WIDTH(32), .NUM_REGS(8), .NUM_READ(3)) dut8 (
    .clk(clk), .reset(reset), .wr_en(e_wr_en), .wr_addr(e_wr_addr), .wr_data(e_wr_data),
    .issue_en(e_issue_en), .issue_addr(e_issue_addr), .rd_addr(e_rd_addr),
    .rd_data(e_rd_data), .rd_pending(e_rd_pending), .pending_vec(e_pending_vec)
  );

  // Scoreboard queue of expected values.
  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic push(input string name, input logic [63:0] exp);
    exp_t t;
    t.name = name;
    t.exp  = exp;
    exp_q.push_back(t);
  endtask

  task automatic pop_check(input logic [63:0] act);
    exp_t t;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL queue_empty: got %h required an expected entry", act);
    end else begin
      t = exp_q.pop_front();
      if (act !== t.exp) begin
        $display("FAIL %s: got %h required %h", t.name, act, t.exp);
      end else begin
        n_pass++;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] e0;
    logic [63:0] e1;
    logic [1:0]  ep;
    logic [31:0] epv;
  } vec_t;

  vec_t vt[17];

  function automatic logic [63:0] mem_exp(input logic [4:0] a);
    case (a)
      5'd2:    return 64'h55;
      5'd5:    return 64'h1234;
      5'd6:    return 64'h66;
      5'd7:    return 64'hAA;
      5'd9:    return 64'h88;
      default: return 64'h0;
    endcase
  endfunction

  task automatic idle_all();
    wr_en = 1'b0; issue_en = 1'b0;
    nb_wr_en = 1'b0; nb_issue_en = 1'b0;
    e_wr_en = 1'b0; e_issue_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table: inputs for one cycle and the outputs seen before the edge.
    vt[0]  = '{1'b1, 5'd5,  64'h1234, 1'b0, 5'd0,  5'd5,  5'd5,  64'h1234, 64'h1234, 2'b00, 32'h0};
    vt[1]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd5,  5'd4,  64'h1234, 64'h0,    2'b00, 32'h0};
    vt[2]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd6,  5'd5,  64'h0,    64'h1234, 2'b00, 32'h0};
    vt[3]  = '{1'b1, 5'd7,  64'hAA,   1'b0, 5'd0,  5'd7,  5'd5,  64'hAA,   64'h1234, 2'b00, 32'h0};
    vt[4]  = '{1'b1, 5'd31, 64'hFFFF, 1'b1, 5'd31, 5'd31, 5'd7,  64'h0,    64'hAA,   2'b00, 32'h0};
    vt[5]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd31, 5'd7,  64'h0,    64'hAA,   2'b00, 32'h0};
    vt[6]  = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd2,  5'd2,  5'd2,  64'h0,    64'h0,    2'b00, 32'h0};
    vt[7]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd2,  5'd5,  64'h0,    64'h1234, 2'b01, 32'h4};
    vt[8]  = '{1'b1, 5'd2,  64'h55,   1'b0, 5'd0,  5'd2,  5'd3,  64'h55,   64'h0,    2'b00, 32'h4};
    vt[9]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd2,  5'd31, 64'h55,   64'h0,    2'b00, 32'h0};
    vt[10] = '{1'b1, 5'd9,  64'h99,   1'b1, 5'd9,  5'd9,  5'd9,  64'h99,   64'h99,   2'b00, 32'h0};
    vt[11] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd9,  5'd2,  64'h99,   64'h55,   2'b01, 32'h200};
    vt[12] = '{1'b1, 5'd9,  64'h77,   1'b1, 5'd9,  5'd9,  5'd9,  64'h77,   64'h77,   2'b11, 32'h200};
    vt[13] = '{1'b1, 5'd9,  64'h88,   1'b0, 5'd0,  5'd9,  5'd5,  64'h88,   64'h1234, 2'b00, 32'h200};
    vt[14] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd9,  5'd31, 64'h88,   64'h0,    2'b00, 32'h0};
    vt[15] = '{1'b1, 5'd6,  64'h66,   1'b1, 5'd4,  5'd4,  5'd6,  64'h0,    64'h66,   2'b00, 32'h0};
    vt[16] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  5'd4,  5'd6,  64'h0,    64'h66,   2'b01, 32'h10};

    reset = 1'b1;
    idle_all();
    wr_addr = '0; wr_data = '0; issue_addr = '0; rd_addr = '0;
    nb_wr_addr = '0; nb_wr_data = '0; nb_issue_addr = '0; nb_rd_addr = '0;
    e_wr_addr = '0; e_wr_data = '0; e_issue_addr = '0; e_rd_addr = '0;

    // Reset state.
    #2;
    push("reset.rd_data0", 64'h0);
    push("reset.pending_vec", 64'h0);
    push("reset.rd_pending", 64'h0);
    pop_check(rd_data[63:0]);
    pop_check({32'h0, pending_vec});
    pop_check({62'h0, rd_pending});
    $display("txn reset_state rd0=%h pvec=%h", rd_data[63:0], pending_vec);

    @(negedge clk);
    reset = 1'b0;

    // Main table on the default build.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      issue_en = vt[i].ie; issue_addr = vt[i].ia;
      rd_addr = {vt[i].ra1, vt[i].ra0};
      push($sformatf("v%0d.rd0", i), vt[i].e0);
      push($sformatf("v%0d.rd1", i), vt[i].e1);
      push($sformatf("v%0d.rd_pending", i), {62'h0, vt[i].ep});
      push($sformatf("v%0d.pending_vec", i), {32'h0, vt[i].epv});
      #2;
      pop_check(rd_data[63:0]);
      pop_check(rd_data[127:64]);
      pop_check({62'h0, rd_pending});
      pop_check({32'h0, pending_vec});
      $display("txn v%0d we=%b wa=%0d ie=%b ia=%0d ra=%0d/%0d rd=%h/%h pend=%b pvec=%h",
               i, vt[i].we, vt[i].wa, vt[i].ie, vt[i].ia, vt[i].ra0, vt[i].ra1,
               rd_data[63:0], rd_data[127:64], rd_pending, pending_vec);
    end

    // One-hot sweep: every address on both ports.
    for (int a = 0; a < 32; a++) begin
      logic [4:0] a0, a1;
      a0 = 5'(a);
      a1 = 5'(31 - a);
      @(negedge clk);
      idle_all();
      rd_addr = {a1, a0};
      push($sformatf("sweep.r%0d", a0), mem_exp(a0));
      push($sformatf("sweep.r%0d", a1), mem_exp(a1));
      #2;
      pop_check(rd_data[63:0]);
      pop_check(rd_data[127:64]);
      $display("txn sweep r%0d=%h r%0d=%h", a0, rd_data[63:0], a1, rd_data[127:64]);
    end

    // No-bypass build: old contents until after the edge; pending not waived.
    @(negedge clk);
    nb_wr_en = 1'b1; nb_wr_addr = 5'd7; nb_wr_data = 64'h11; nb_rd_addr = {5'd7, 5'd7};
    nb_issue_en = 1'b1; nb_issue_addr = 5'd3;
    push("nb.first_write_old", 64'h0);
    #2; pop_check(nb_rd_data[63:0]);
    $display("txn nb write r7=11 rd0=%h", nb_rd_data[63:0]);
    @(negedge clk);
    nb_issue_en = 1'b0;
    nb_wr_data = 64'hAA; nb_rd_addr = {5'd3, 5'd7};
    push("nb.same_cycle_old", 64'h11);
    push("nb.pending_r3", 64'h1);
    #2; pop_check(nb_rd_data[63:0]); pop_check({63'h0, nb_rd_pending[1]});
    $display("txn nb write r7=AA rd0=%h pend1=%b", nb_rd_data[63:0], nb_rd_pending[1]);
    @(negedge clk);
    nb_wr_addr = 5'd3; nb_wr_data = 64'h33;
    push("nb.after_edge", 64'hAA);
    push("nb.write_no_waive", 64'h1);
    push("nb.r3_old", 64'h0);
    #2; pop_check(nb_rd_data[63:0]); pop_check({63'h0, nb_rd_pending[1]});
    pop_check(nb_rd_data[127:64]);
    $display("txn nb write r3=33 rd=%h/%h pend=%b", nb_rd_data[63:0], nb_rd_data[127:64], nb_rd_pending);
    @(negedge clk);
    nb_wr_en = 1'b0;
    push("nb.r3_cleared", 64'h0);
    push("nb.r3_data", 64'h33);
    #2; pop_check({63'h0, nb_rd_pending[1]}); pop_check(nb_rd_data[127:64]);
    $display("txn nb idle rd1=%h pend1=%b", nb_rd_data[127:64], nb_rd_pending[1]);

    // Small build: simultaneous issue+write, three ports, zero register r7.
    @(negedge clk);
    e_wr_en = 1'b1; e_wr_addr = 3'd1; e_wr_data = 32'hCAFE0001;
    e_issue_en = 1'b1; e_issue_addr = 3'd1; e_rd_addr = {3'd1, 3'd1, 3'd1};
    for (int p = 0; p < 3; p++) push($sformatf("e8.bypass_p%0d", p), 64'hCAFE0001);
    push("e8.pvec0", 64'h0);
    #2;
    pop_check({32'h0, e_rd_data[31:0]}); pop_check({32'h0, e_rd_data[63:32]});
    pop_check({32'h0, e_rd_data[95:64]}); pop_check({56'h0, e_pending_vec});
    $display("txn e8 issue+write r1 rd=%h pvec=%h", e_rd_data, e_pending_vec);
    @(negedge clk);
    e_wr_en = 1'b0; e_issue_en = 1'b0; e_rd_addr = {3'd7, 3'd1, 3'd1};
    push("e8.r1_p0", 64'hCAFE0001); push("e8.r1_p1", 64'hCAFE0001); push("e8.r7_p2", 64'h0);
    push("e8.rd_pending", 64'h3); push("e8.pvec1", 64'h2);
    #2;
    pop_check({32'h0, e_rd_data[31:0]}); pop_check({32'h0, e_rd_data[63:32]});
    pop_check({32'h0, e_rd_data[95:64]}); pop_check({61'h0, e_rd_pending});
    pop_check({56'h0, e_pending_vec});
    $display("txn e8 idle rd=%h pend=%b pvec=%h", e_rd_data, e_rd_pending, e_pending_vec);
    @(negedge clk);
    e_wr_en = 1'b1; e_wr_addr = 3'd7; e_wr_data = 32'hFFFFFFFF;
    e_issue_en = 1'b1; e_issue_addr = 3'd7; e_rd_addr = {3'd1, 3'd7, 3'd7};
    push("e8.zero_p0", 64'h0); push("e8.zero_p1", 64'h0); push("e8.r1_p2", 64'hCAFE0001);
    push("e8.zero_pending", 64'h4);
    #2;
    pop_check({32'h0, e_rd_data[31:0]}); pop_check({32'h0, e_rd_data[63:32]});
    pop_check({32'h0, e_rd_data[95:64]}); pop_check({61'h0, e_rd_pending});
    $display("txn e8 write+issue r7 rd=%h pend=%b", e_rd_data, e_rd_pending);
    @(negedge clk);
    e_wr_en = 1'b0; e_issue_en = 1'b0; e_rd_addr = {3'd1, 3'd0, 3'd7};
    push("e8.zero_after", 64'h0); push("e8.pvec_no_r7", 64'h2);
    #2;
    pop_check({32'h0, e_rd_data[31:0]}); pop_check({56'h0, e_pending_vec});
    $display("txn e8 idle r7=%h pvec=%h", e_rd_data[31:0], e_pending_vec);

    // Reset mid-cycle clears storage and scoreboard immediately.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEAD;
    issue_en = 1'b1; issue_addr = 5'd3;
    @(negedge clk);
    idle_all(); rd_addr = {5'd0, 5'd3};
    push("pre_reset.r3", 64'hDEAD); push("pre_reset.pvec", 64'h18);
    #2; pop_check(rd_data[63:0]); pop_check({32'h0, pending_vec});
    $display("txn pre_reset r3=%h pvec=%h", rd_data[63:0], pending_vec);
    #1 reset = 1'b1;
    push("reset_mid.r3", 64'h0); push("reset_mid.pvec", 64'h0);
    push("reset_mid.rd_pending", 64'h0); push("reset_mid.e8_pvec", 64'h0);
    #1;
    pop_check(rd_data[63:0]); pop_check({32'h0, pending_vec});
    pop_check({62'h0, rd_pending}); pop_check({56'h0, e_pending_vec});
    $display("txn reset_mid r3=%h pvec=%h e8pvec=%h", rd_data[63:0], pending_vec, e_pending_vec);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h77;
    @(negedge clk);
    wr_en = 1'b0;
    push("reset_overrides_write", 64'h0);
    #2; pop_check(rd_data[63:0]);
    $display("txn reset_hold r3=%h", rd_data[63:0]);
    reset = 1'b0;
    wr_en = 1'b1; wr_data = 64'h42;
    @(negedge clk);
    wr_en = 1'b0;
    push("first_edge_after_release", 64'h42);
    #2; pop_check(rd_data[63:0]);
    $display("txn post_release r3=%h", rd_data[63:0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
